schematic_counter: RTL and testbench
====================================

# schematic_counter

4-bit registered incrementer forming the datapath of a gate-level ("schematic-style") binary up-counter. Each rising clock edge registers the 4-bit value on `d3..d0` plus one onto `result`. Count sequencing comes from feeding `result` back to `d3..d0` outside the block, in the parent or bench. The block has no enable and no terminal-count output.

## Interface
- No parameters. Width is fixed at 4 bits.
- `clk`  input  1  rising-edge clock, single clock domain.
- `reset`  input  1  asynchronous, active-low reset. `reset` = 0 clears `result` immediately, independent of `clk`.
- `d0`  input  1  operand bit 0 (LSB).
- `d1`  input  1  operand bit 1.
- `d2`  input  1  operand bit 2.
- `d3`  input  1  operand bit 3 (MSB).
- `result`  output  4  registered sum {d3,d2,d1,d0} + 1 mod 16. `result[0]` is the LSB.

## Operation
- Datapath is built structurally: a ripple incrementer of four half-adder cells feeding four D flip-flops. The carry-in of bit 0 is tied to 1.
  - Bit i sum = d_i XOR c_i.
  - c_(i+1) = d_i AND c_i.
  - c_0 = 1.
- Final carry-out (c_4) is discarded. The block has no overflow flag.
- Each flip-flop has an asynchronous active-low clear driven by `reset`.
- While `reset` = 1, on each rising edge of `clk`: `result` <= {d3,d2,d1,d0} + 1, truncated to 4 bits.
- Wrap-around: operand 1111 produces 0000 on the next edge, with no error indication.
- Operands are arbitrary. The block does not check that `d` equals the previous `result`. Any 4-bit value is incremented.
- Reset behaviour:
  - `reset` = 0 forces `result` = 0000 asynchronously, within the same delta/gate delay, with no clock needed.
  - `result` is held at 0000 while `reset` stays low. Clock edges during reset are ignored.
- Reset deassertion: the first rising `clk` edge with `reset` = 1 loads d+1. No extra synchronizer stage is added inside the block.
- Reset asserted mid-operation, i.e. at any clock phase, clears `result` regardless of its current value or the operands.
- Reset asserted coincident with a clock edge: reset wins and `result` = 0000.
- Unknown or X operands produce X on `result` after the next edge. No X-masking is required.

## Timing
- Latency: one clock. `result` reflects the `d` sampled at rising edge N, valid after clk-to-q of edge N and stable until edge N+1.
- Operands may change anywhere in the cycle, provided they meet setup/hold around the rising edge. The ripple carry path (3 AND stages plus XOR) must close within one period.
  - Reference clock: 20 ns period, 50% duty.
- External feedback loop (`result` -> `d`) yields the sequence 0,1,2,…,15,0,… with one step per loaded operand.
  - Because of the one-cycle latency, the count advances once per clock only if the parent copies `result` to `d` every cycle.
- Reset assertion takes effect asynchronously. Reset removal is synchronous to the next rising edge.

## Test plan
- Power-up reset: `reset` = 0, `d` = 1010, clock running → `result` = 0000 throughout. Release `reset` → the next edge gives `result` = 1011.
- Basic increment: `reset` = 1, `d` = 0000, one rising edge → `result` = 0001. Then `d` = 0111 → next edge `result` = 1000, exercising the full carry ripple to bit 3.
- Wrap-around: `d` = 1111, one edge → `result` = 0000. `d` = 1110 → `result` = 1111.
- Non-sequential operands: apply 0101, 0011, 1001 on successive edges → `result` = 0110, 0100, 1010 respectively.
- Feedback count: bench copies `result` to `d` after each edge, starting from reset → displayed count runs 0000…1111 then 0000, across 17 or more steps, with no skips.
- Mid-operation reset: during the feedback count at `result` = 1100, pulse `reset` low between edges → `result` = 0000 immediately, before the next edge. After release, counting resumes from 0001.

Source files
------------

// File: rtl/schematic_counter.sv
// 4-bit registered incrementer: result <= {d3,d2,d1,d0} + 1, one-clock latency, no handshake.
// Built as a ripple of half-adder cells into async-clear D flip-flops; reset (active-low) clears instantly.

module schematic_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module schematic_dff (
  input  logic clk,
  input  logic clr_n,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) q <= 1'b0;
    else        q <= d;
  end
endmodule

module schematic_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       d0,
  input  logic       d1,
  input  logic       d2,
  input  logic       d3,
  output logic [3:0] result
);
  logic [3:0] opnd;
  logic [3:0] carry;
  logic [3:0] sum;

  assign opnd     = {d3, d2, d1, d0};
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < 4; i++) begin : g_bit
    if (i < 3) begin : g_ha
      schematic_ha u_ha (
        .a (opnd[i]),
        .b (carry[i]),
        .s (sum[i]),
        .c (carry[i+1])
      );
    end else begin : g_msb
      // MSB cell keeps only the sum; the carry out wraps away with no overflow flag
      assign sum[i] = opnd[i] ^ carry[i];
    end

    schematic_dff u_ff (
      .clk   (clk),
      .clr_n (reset),
      .d     (sum[i]),
      .q     (result[i])
    );
  end
endmodule

// File: tb/tb_schematic_counter.sv
// Scoreboard bench for schematic_counter: stimulus queues the expected register value for the next edge,
// a monitor pops and compares just after each rising edge; async-reset clears are checked on the spot.

module tb_schematic_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic       d0, d1, d2, d3;
  logic [3:0] result;

  typedef struct {
    logic [3:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  logic [3:0] cnt;

  schematic_counter dut (
    .clk    (clk),
    .reset  (reset),
    .d0     (d0),
    .d1     (d1),
    .d2     (d2),
    .d3     (d3),
    .result (result)
  );

  always #10 clk = ~clk;

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) $display("FAIL %s: result=%b expected=%b at %0t", name, got, want, $time);
    else passes++;
  endtask

  task automatic set_d(input logic [3:0] v);
    {d3, d2, d1, d0} = v;
  endtask

  // Drive an operand at the falling edge and queue what the next rising edge must register.
  task automatic apply(input logic [3:0] v, input logic [3:0] want, input string name);
    @(negedge clk);
    set_d(v);
    q.push_back('{want, name});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        check(e.name, result, e.val);
      end
    end
  end

  initial begin : stim
    reset = 1'b0;
    set_d(4'b1010);
    #1;
    check("powerup_async_clear", result, 4'b0000);

    // clock edges while reset is low must be ignored
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      q.push_back('{4'b0000, "reset_hold"});
    end

    @(negedge clk);
    reset = 1'b1;
    q.push_back('{4'b1011, "reset_release"});

    apply(4'b0000, 4'b0001, "inc_0000");
    apply(4'b0111, 4'b1000, "ripple_0111");
    apply(4'b1111, 4'b0000, "wrap_1111");
    apply(4'b1110, 4'b1111, "inc_1110");
    apply(4'b0101, 4'b0110, "nonseq_0101");
    apply(4'b0011, 4'b0100, "nonseq_0011");
    apply(4'b1001, 4'b1010, "nonseq_1001");

    // restart from reset and run the feedback count
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("count_start_clear", result, 4'b0000);
    q.push_back('{4'b0000, "count_start_hold"});

    @(negedge clk);
    reset = 1'b1;
    set_d(result);
    cnt = 4'b0001;
    q.push_back('{cnt, "count_step"});

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      set_d(result);
      cnt = cnt + 4'd1;
      q.push_back('{cnt, "count_step"});
    end

    // model now holds 1100: pulse reset between edges
    @(negedge clk);
    check("count_at_1100", result, 4'b1100);
    reset = 1'b0;
    #2;
    check("midop_async_clear", result, 4'b0000);
    #2;
    reset = 1'b1;
    #1;
    check("midop_held_after_release", result, 4'b0000);
    set_d(result);
    cnt = 4'b0001;
    q.push_back('{cnt, "resume_step"});

    // 18 more steps: 2..15, wrap to 0, then 1..3
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      set_d(result);
      cnt = cnt + 4'd1;
      q.push_back('{cnt, "count_step"});
    end

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) $display("FAIL scoreboard_drain: pending=%0d expected=0", q.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
